// File: rtl/seg_disp_arbiter_pkg.sv
// rtl/seg_disp_arbiter_pkg.sv - shared seg display constants, arbiter states and helpers
package seg_disp_arbiter_pkg;

   localparam logic [19:0] MAX_DISP = 20'd999999;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_OPEN = 2'd2
   } arb_state_e;

   typedef logic [1:0] owner_idx_t;

   function automatic owner_idx_t onehot_to_idx(input logic [2:0] oh);
      owner_idx_t idx;
      idx = 2'd0;
      if (oh[1]) idx = 2'd1;
      if (oh[2]) idx = 2'd2;
      return idx;
   endfunction

   function automatic logic [19:0] sat_disp(input logic [19:0] v);
      return (v > MAX_DISP) ? MAX_DISP : v;
   endfunction

endpackage

// File: rtl/seg_disp_arbiter_if.sv
// rtl/seg_disp_arbiter_if.sv - requester bundle and display-side outputs of the arbiter
interface seg_disp_arbiter_if;
   logic [2:0]  req;
   logic [19:0] data0;
   logic [19:0] data1;
   logic [19:0] data2;
   logic [5:0]  point0;
   logic [5:0]  point1;
   logic [5:0]  point2;
   logic        sign0;
   logic        sign1;
   logic        sign2;
   logic [2:0]  grant;
   logic [19:0] data;
   logic [5:0]  point;
   logic        sign;
   logic        en;

   modport master (
      output req, data0, data1, data2, point0, point1, point2, sign0, sign1, sign2,
      input  grant, data, point, sign, en
   );

   modport slave (
      input  req, data0, data1, data2, point0, point1, point2, sign0, sign1, sign2,
      output grant, data, point, sign, en
   );
endinterface

// File: rtl/seg_disp_arbiter_rr_pick3.sv
// rtl/seg_disp_arbiter_rr_pick3.sv - 3-way round-robin pick starting after the last owner
module rr_pick3
   import seg_disp_arbiter_pkg::*;
(
   input  logic [2:0] req_mask,
   input  owner_idx_t last_owner,
   output logic [2:0] win,
   output logic       valid
);

   always_comb begin
      win   = 3'b000;
      valid = |req_mask;
      case (last_owner)
         2'd0: begin
            if      (req_mask[1]) win = 3'b010;
            else if (req_mask[2]) win = 3'b100;
            else if (req_mask[0]) win = 3'b001;
         end
         2'd1: begin
            if      (req_mask[2]) win = 3'b100;
            else if (req_mask[0]) win = 3'b001;
            else if (req_mask[1]) win = 3'b010;
         end
         default: begin
            if      (req_mask[0]) win = 3'b001;
            else if (req_mask[1]) win = 3'b010;
            else if (req_mask[2]) win = 3'b100;
         end
      endcase
   end

endmodule

// File: rtl/seg_disp_arbiter.sv
// rtl/seg_disp_arbiter.sv - display ownership arbiter with minimum hold and saturating output mux
module seg_disp_arbiter
   import seg_disp_arbiter_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 50_000_000
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   seg_disp_arbiter_if.slave bus
);

   localparam int unsigned      CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

   arb_state_e       state_q, state_d;
   logic [2:0]       grant_q, grant_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   owner_idx_t       last_q, last_d;
   logic [19:0]      data_q, data_d;
   logic [5:0]       point_q, point_d;
   logic             sign_q, sign_d;
   logic             en_q, en_d;

   logic [2:0] pick_win;
   logic       pick_valid;
   logic       owner_live;

   // Candidates always exclude the current owner; in IDLE grant_q is zero so all requests count.
   rr_pick3 u_rr (
      .req_mask   (bus.req & ~grant_q),
      .last_owner (last_q),
      .win        (pick_win),
      .valid      (pick_valid)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= 3'b000;
         cnt_q   <= '0;
         last_q  <= 2'd2;
         data_q  <= '0;
         point_q <= '0;
         sign_q  <= 1'b0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         data_q  <= data_d;
         point_q <= point_d;
         sign_q  <= sign_d;
         en_q    <= en_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      owner_live = |(bus.req & grant_q);
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d = ST_HOLD;
               grant_d = pick_win;
               cnt_d   = '0;
               last_d  = onehot_to_idx(pick_win);
            end
         end
         ST_HOLD: begin
            if (!owner_live) begin
               if (pick_valid) begin
                  grant_d = pick_win;
                  cnt_d   = '0;
                  last_d  = onehot_to_idx(pick_win);
               end else begin
                  state_d = ST_IDLE;
                  grant_d = 3'b000;
                  cnt_d   = '0;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_OPEN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_OPEN: begin
            if (pick_valid) begin
               state_d = ST_HOLD;
               grant_d = pick_win;
               cnt_d   = '0;
               last_d  = onehot_to_idx(pick_win);
            end else if (!owner_live) begin
               state_d = ST_IDLE;
               grant_d = 3'b000;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 3'b000;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs follow the owner selected at this same edge, so a new grant shows its data at once.
   always_comb begin
      data_d  = '0;
      point_d = '0;
      sign_d  = 1'b0;
      case (grant_d)
         3'b001: begin
            data_d  = sat_disp(bus.data0);
            point_d = bus.point0;
            sign_d  = bus.sign0;
         end
         3'b010: begin
            data_d  = sat_disp(bus.data1);
            point_d = bus.point1;
            sign_d  = bus.sign1;
         end
         3'b100: begin
            data_d  = sat_disp(bus.data2);
            point_d = bus.point2;
            sign_d  = bus.sign2;
         end
         default: begin
            data_d  = '0;
            point_d = '0;
            sign_d  = 1'b0;
         end
      endcase
      en_d = |grant_d;
   end

   assign bus.grant = grant_q;
   assign bus.data  = data_q;
   assign bus.point = point_q;
   assign bus.sign  = sign_q;
   assign bus.en    = en_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// tb/tb_seg_disp_arbiter.sv - scoreboard bench for seg_disp_arbiter with HOLD_CYCLES=10
module tb_seg_disp_arbiter;

   typedef struct packed {
      logic [2:0]  grant;
      logic        en;
      logic [19:0] data;
      logic [5:0]  point;
      logic        sign;
   } out_t;

   localparam logic [19:0] D0 = 20'd111111;
   localparam logic [19:0] D1 = 20'd222222;
   localparam logic [19:0] D2 = 20'd333333;

   logic sys_clk = 1'b0;
   logic sys_rst_n;
   int   checks = 0;
   int   errors = 0;
   out_t  exp_q[$];
   string name_q[$];

   seg_disp_arbiter_if dif();

   seg_disp_arbiter #(.HOLD_CYCLES(10)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (dif)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic out_t actual_out();
      out_t a;
      a.grant = dif.grant;
      a.en    = dif.en;
      a.data  = dif.data;
      a.point = dif.point;
      a.sign  = dif.sign;
      return a;
   endfunction

   function automatic logic [19:0] sat(input logic [19:0] v);
      return (v > 20'd999999) ? 20'd999999 : v;
   endfunction

   function automatic out_t expect_for(input logic [2:0] g);
      out_t e;
      e = '0;
      e.grant = g;
      e.en    = (g != 3'b000);
      case (g)
         3'b001:  begin e.data = sat(dif.data0); e.point = dif.point0; e.sign = dif.sign0; end
         3'b010:  begin e.data = sat(dif.data1); e.point = dif.point1; e.sign = dif.sign1; end
         3'b100:  begin e.data = sat(dif.data2); e.point = dif.point2; e.sign = dif.sign2; end
         default: begin e.data = '0; e.point = '0; e.sign = 1'b0; end
      endcase
      return e;
   endfunction

   task automatic compare(input string nm, input out_t e);
      out_t a;
      a = actual_out();
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got grant=%b en=%b data=%0d point=%b sign=%b, want grant=%b en=%b data=%0d point=%b sign=%b",
                  nm, a.grant, a.en, a.data, a.point, a.sign, e.grant, e.en, e.data, e.point, e.sign);
      end
   endtask

   task automatic step(input logic [2:0] r, input logic [2:0] eg, input logic [19:0] d0, input string nm);
      @(negedge sys_clk);
      dif.req   = r;
      dif.data0 = d0;
      exp_q.push_back(expect_for(eg));
      name_q.push_back(nm);
   endtask

   initial begin
      forever begin
         @(posedge sys_clk);
         #1;
         if (exp_q.size() > 0) compare(name_q.pop_front(), exp_q.pop_front());
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout, want bench completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      sys_rst_n  = 1'b0;
      dif.req    = 3'b000;
      dif.data0  = D0;
      dif.data1  = D1;
      dif.data2  = D2;
      dif.point0 = 6'b000001;
      dif.point1 = 6'b000010;
      dif.point2 = 6'b000100;
      dif.sign0  = 1'b0;
      dif.sign1  = 1'b1;
      dif.sign2  = 1'b0;

      step(3'b000, 3'b000, D0, "reset_idle_a");
      step(3'b000, 3'b000, D0, "reset_idle_b");
      #2 sys_rst_n = 1'b1;

      step(3'b011, 3'b001, D0, "req011_grant0");
      for (int k = 1; k <= 10; k++) step(3'b011, 3'b001, D0, $sformatf("hold0_%0d", k));
      step(3'b011, 3'b010, D0, "open_preempt_to1");

      for (int k = 1; k <= 3; k++) step(3'b111, 3'b010, D0, $sformatf("hold1_others_%0d", k));
      step(3'b101, 3'b100, D0, "release1_to2");
      step(3'b100, 3'b100, D0, "hold2");
      step(3'b001, 3'b001, D0, "release2_to0");

      step(3'b001, 3'b001, 20'd1000000, "sat_1000000");
      step(3'b001, 3'b001, 20'd123456, "track_123456");
      for (int k = 4; k <= 30; k++) step(3'b001, 3'b001, 20'd123456, $sformatf("only0_%0d", k));
      step(3'b000, 3'b000, 20'd123456, "drop_to_idle");
      step(3'b000, 3'b000, 20'd123456, "idle_stays");

      step(3'b010, 3'b010, D0, "idle_grant1");
      step(3'b010, 3'b010, D0, "hold1_a");
      step(3'b010, 3'b010, D0, "hold1_b");

      @(negedge sys_clk);
      #2;
      sys_rst_n = 1'b0;
      dif.req   = 3'b000;
      #1;
      compare("async_reset_zero", out_t'(0));
      @(negedge sys_clk);
      #3 sys_rst_n = 1'b1;

      step(3'b111, 3'b001, D0, "post_reset_rr");
      for (int k = 1; k <= 10; k++) step(3'b111, 3'b001, D0, $sformatf("post_hold0_%0d", k));
      step(3'b111, 3'b010, D0, "open_preempt_rr");

      repeat (3) @(posedge sys_clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
